// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the naked-single elimination scanner.
package sudoku_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        JUDGE     = 3'd2,
        ELIMINATE = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Widest candidate mask the helpers accept; narrower masks are zero-extended.
    localparam int unsigned MASK_MAXW = 64;

    function automatic logic is_single(input logic [MASK_MAXW-1:0] mask);
        return (mask != '0) && ((mask & (mask - MASK_MAXW'(1))) == '0);
    endfunction

    function automatic logic [7:0] box_of(input logic [7:0] bx, input logic [7:0] by,
                                          input logic [7:0] box);
        return 8'((16'(by) * 16'(box)) + 16'(bx));
    endfunction

endpackage

// File: rtl/sudoku_elim_scanner_if.sv
// Start/done handshake and grid payload between loader/controller and the scanner.
interface sudoku_elim_scanner_if #(
    parameter int unsigned BOX        = 3,
    parameter int unsigned MAX_PASSES = 16
);
    localparam int unsigned N  = BOX * BOX;
    localparam int unsigned PW = $clog2(MAX_PASSES + 1);

    logic                       i_Start;
    logic [N-1:0][N-1:0][N-1:0] i_Grid;
    logic [N-1:0][N-1:0][N-1:0] o_Grid;
    logic                       o_Busy;
    logic                       o_Done;
    logic                       o_Complete;
    logic                       o_Contradiction;
    logic [PW-1:0]              o_Passes;

    modport master (
        output i_Start, i_Grid,
        input  o_Grid, o_Busy, o_Done, o_Complete, o_Contradiction, o_Passes
    );

    modport slave (
        input  i_Start, i_Grid,
        output o_Grid, o_Busy, o_Done, o_Complete, o_Contradiction, o_Passes
    );
endinterface

// File: rtl/cell_index_gen.sv
// Row-major (x fastest) cell walker with box coordinates kept without dividers.
module cell_index_gen #(
    parameter int unsigned BOX = 3,
    localparam int unsigned N  = BOX * BOX,
    localparam int unsigned XW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [XW-1:0] y_o,
    output logic [XW-1:0] bx_o,
    output logic [XW-1:0] by_o,
    output logic          last_o
);
    logic [XW-1:0] x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;
    logic [XW-1:0] xs_q, xs_d, ys_q, ys_d;
    logic          last_q, last_d;

    // xs/ys count position inside the current box so bx/by step every BOX cells.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        bx_d   = bx_q;
        by_d   = by_q;
        xs_d   = xs_q;
        ys_d   = ys_q;
        last_d = last_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            bx_d   = '0;
            by_d   = '0;
            xs_d   = '0;
            ys_d   = '0;
            last_d = 1'b0;
        end else if (advance_i) begin
            if (x_q == XW'(N - 1)) begin
                x_d  = '0;
                xs_d = '0;
                bx_d = '0;
                if (y_q == XW'(N - 1)) begin
                    y_d  = '0;
                    ys_d = '0;
                    by_d = '0;
                end else if (ys_q == XW'(BOX - 1)) begin
                    y_d  = y_q + XW'(1);
                    ys_d = '0;
                    by_d = by_q + XW'(1);
                end else begin
                    y_d  = y_q + XW'(1);
                    ys_d = ys_q + XW'(1);
                end
            end else if (xs_q == XW'(BOX - 1)) begin
                x_d  = x_q + XW'(1);
                xs_d = '0;
                bx_d = bx_q + XW'(1);
            end else begin
                x_d  = x_q + XW'(1);
                xs_d = xs_q + XW'(1);
            end
            last_d = (x_d == XW'(N - 1)) && (y_d == XW'(N - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            xs_q   <= '0;
            ys_q   <= '0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            last_q <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign bx_o   = bx_q;
    assign by_o   = by_q;
    assign last_o = last_q;
endmodule

// File: rtl/sudoku_elim_scanner.sv
// Time-multiplexed naked-single eliminator: alternates used-mask collection and
// elimination passes over an N x N candidate grid until solved, stuck or inconsistent.
module sudoku_elim_scanner
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX        = 3,
    parameter int unsigned MAX_PASSES = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    sudoku_elim_scanner_if.slave bus
);
    localparam int unsigned N  = BOX * BOX;
    localparam int unsigned NN = N * N;
    localparam int unsigned XW = $clog2(N);
    localparam int unsigned SW = $clog2(NN + 1);
    localparam int unsigned PW = $clog2(MAX_PASSES + 1);

    state_e                     state_q;
    logic [N-1:0][N-1:0][N-1:0] grid_q;
    logic [N-1:0][N-1:0]        row_used_q, col_used_q, box_used_q;
    logic [SW-1:0]              solved_cnt_q;
    logic                       contra_q, changed_q;
    logic                       busy_q, done_q, complete_q, contradiction_q;
    logic [PW-1:0]              passes_q;

    logic [XW-1:0] cx, cy, cbx, cby, cb;
    logic          last_cell, idx_clear, idx_advance;
    logic [N-1:0]  cell_mask, used_mask, elim_mask;
    logic          cell_single;

    assign idx_advance = (state_q == COLLECT) || (state_q == ELIMINATE);
    assign idx_clear   = !idx_advance;

    cell_index_gen #(.BOX(BOX)) u_idx (
        .clk       (i_Clk),
        .rst_n     (i_Rst_n),
        .clear_i   (idx_clear),
        .advance_i (idx_advance),
        .x_o       (cx),
        .y_o       (cy),
        .bx_o      (cbx),
        .by_o      (cby),
        .last_o    (last_cell)
    );

    assign cb          = XW'(box_of(8'(cbx), 8'(cby), 8'(BOX)));
    assign cell_mask   = grid_q[cx][cy];
    assign used_mask   = row_used_q[cy] | col_used_q[cx] | box_used_q[cb];
    assign elim_mask   = cell_mask & ~used_mask;
    assign cell_single = is_single(MASK_MAXW'(cell_mask));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q         <= IDLE;
            grid_q          <= '0;
            row_used_q      <= '0;
            col_used_q      <= '0;
            box_used_q      <= '0;
            solved_cnt_q    <= '0;
            contra_q        <= 1'b0;
            changed_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            complete_q      <= 1'b0;
            contradiction_q <= 1'b0;
            passes_q        <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_Start) begin
                        grid_q          <= bus.i_Grid;
                        complete_q      <= 1'b0;
                        contradiction_q <= 1'b0;
                        passes_q        <= '0;
                        contra_q        <= 1'b0;
                        row_used_q      <= '0;
                        col_used_q      <= '0;
                        box_used_q      <= '0;
                        solved_cnt_q    <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cell_mask == '0) begin
                        contra_q <= 1'b1;
                    end else if (cell_single) begin
                        if ((cell_mask & used_mask) != '0) begin
                            contra_q <= 1'b1;
                        end else begin
                            row_used_q[cy] <= row_used_q[cy] | cell_mask;
                            col_used_q[cx] <= col_used_q[cx] | cell_mask;
                            box_used_q[cb] <= box_used_q[cb] | cell_mask;
                            solved_cnt_q   <= solved_cnt_q + SW'(1);
                        end
                    end
                    if (last_cell) state_q <= JUDGE;
                end
                JUDGE: begin
                    if (contra_q) begin
                        contradiction_q <= 1'b1;
                        done_q          <= 1'b1;
                        state_q         <= DONE;
                    end else if (solved_cnt_q == SW'(NN)) begin
                        complete_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        changed_q <= 1'b0;
                        state_q   <= ELIMINATE;
                    end
                end
                ELIMINATE: begin
                    // Used masks stay frozen for the whole pass; new singles count next pass.
                    if (!cell_single) begin
                        grid_q[cx][cy] <= elim_mask;
                        if (elim_mask != cell_mask) changed_q <= 1'b1;
                        if (elim_mask == '0) contra_q <= 1'b1;
                    end
                    if (last_cell) begin
                        if (passes_q != PW'(MAX_PASSES)) passes_q <= passes_q + PW'(1);
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (contra_q) begin
                        contradiction_q <= 1'b1;
                        done_q          <= 1'b1;
                        state_q         <= DONE;
                    end else if (!changed_q || (passes_q == PW'(MAX_PASSES))) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_used_q   <= '0;
                        col_used_q   <= '0;
                        box_used_q   <= '0;
                        solved_cnt_q <= '0;
                        state_q      <= COLLECT;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Grid          = grid_q;
    assign bus.o_Busy          = busy_q;
    assign bus.o_Done          = done_q;
    assign bus.o_Complete      = complete_q;
    assign bus.o_Contradiction = contradiction_q;
    assign bus.o_Passes        = passes_q;
endmodule

// File: tb/tb_sudoku_elim_scanner.sv
// Bench for sudoku_elim_scanner: BOX=2 and BOX=3 instances against a grid-level reference model.
module tb_sudoku_elim_scanner;
    localparam int unsigned MAXP = 16;
    typedef int unsigned grid_t [9][9];

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sudoku_elim_scanner_if #(.BOX(2), .MAX_PASSES(MAXP)) if2 ();
    sudoku_elim_scanner_if #(.BOX(3), .MAX_PASSES(MAXP)) if3 ();

    sudoku_elim_scanner #(.BOX(2), .MAX_PASSES(MAXP)) dut2 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if2));
    sudoku_elim_scanner #(.BOX(3), .MAX_PASSES(MAXP)) dut3 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference solution: each row is the previous row shifted, rows stepped box-wise.
    function automatic grid_t sol_grid(input int box);
        grid_t g;
        int n = box * box;
        g = '{default: 0};
        for (int x = 0; x < n; x++)
            for (int y = 0; y < n; y++)
                g[x][y] = 1 << ((box * (y % box) + y / box + x) % n);
        return g;
    endfunction

    function automatic grid_t rand_grid(input int box);
        grid_t g;
        int n = box * box;
        int unsigned full = (1 << n) - 1;
        int mode = $urandom_range(0, 3);
        int r;
        g = sol_grid(box);
        for (int x = 0; x < n; x++)
            for (int y = 0; y < n; y++) begin
                r = $urandom_range(0, 9);
                if (r >= 4 && r < 8) g[x][y] = g[x][y] | ($urandom & full);
                else if (r >= 8) g[x][y] = full;
            end
        r = $urandom_range(0, n * n - 1);
        if (mode == 1) g[r % n][r / n] = 1 << $urandom_range(0, n - 1);
        else if (mode == 2) g[r % n][r / n] = 0;
        else if (mode == 3) g[r % n][r / n] = $urandom & full;
        return g;
    endfunction

    // Grid-level model: whole-grid collection then whole-grid elimination per pass.
    task automatic model(input int box, input grid_t gin, output grid_t g, output bit comp,
                         output bit contra, output int passes, output int lat);
        int n = box * box;
        int unsigned full = (1 << n) - 1;
        int unsigned rowu[9], colu[9], boxu[9];
        int unsigned m, nm, u;
        int solved, b;
        bit changed;
        g = gin; comp = 0; contra = 0; passes = 0; lat = 0;
        forever begin
            rowu = '{default: 0}; colu = '{default: 0}; boxu = '{default: 0};
            solved = 0;
            for (int y = 0; y < n; y++)
                for (int x = 0; x < n; x++) begin
                    m = g[x][y];
                    b = (y / box) * box + x / box;
                    if (m == 0) contra = 1;
                    else if ($countones(m) == 1) begin
                        if ((m & (rowu[y] | colu[x] | boxu[b])) != 0) contra = 1;
                        else begin
                            rowu[y] |= m; colu[x] |= m; boxu[b] |= m;
                            solved++;
                        end
                    end
                end
            lat += n * n + 1;
            if (contra) break;
            if (solved == n * n) begin comp = 1; break; end
            changed = 0;
            for (int x = 0; x < n; x++)
                for (int y = 0; y < n; y++) begin
                    m = g[x][y];
                    if ($countones(m) != 1) begin
                        b  = (y / box) * box + x / box;
                        u  = rowu[y] | colu[x] | boxu[b];
                        nm = m & ~u & full;
                        if (nm != m) changed = 1;
                        if (nm == 0) contra = 1;
                        g[x][y] = nm;
                    end
                end
            if (passes < MAXP) passes++;
            lat += n * n + 1;
            if (contra || !changed || passes == MAXP) break;
        end
        lat += 1;
    endtask

    task automatic drive(input int box, input grid_t g, input logic start);
        if (box == 2) begin
            if2.i_Start = start;
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++) if2.i_Grid[x][y] = 4'(g[x][y]);
        end else begin
            if3.i_Start = start;
            for (int x = 0; x < 9; x++)
                for (int y = 0; y < 9; y++) if3.i_Grid[x][y] = 9'(g[x][y]);
        end
    endtask

    // which: 0 busy, 1 done, 2 complete, 3 contradiction, 4 passes
    function automatic logic [63:0] dut_out(input int box, input int which);
        if (box == 2)
            case (which)
                0: return 64'(if2.o_Busy);
                1: return 64'(if2.o_Done);
                2: return 64'(if2.o_Complete);
                3: return 64'(if2.o_Contradiction);
                default: return 64'(if2.o_Passes);
            endcase
        else
            case (which)
                0: return 64'(if3.o_Busy);
                1: return 64'(if3.o_Done);
                2: return 64'(if3.o_Complete);
                3: return 64'(if3.o_Contradiction);
                default: return 64'(if3.o_Passes);
            endcase
    endfunction

    function automatic int grid_diff(input int box, input grid_t e);
        int cnt = 0;
        logic [8:0] v;
        for (int x = 0; x < box * box; x++)
            for (int y = 0; y < box * box; y++) begin
                v = (box == 2) ? 9'(if2.o_Grid[x][y]) : if3.o_Grid[x][y];
                if (v !== 9'(e[x][y])) cnt++;
            end
        return cnt;
    endfunction

    task automatic run(input int box, input grid_t gin, input string tag);
        grid_t eg;
        bit ecomp, econ;
        int epass, elat, cyc;
        bit seen;
        model(box, gin, eg, ecomp, econ, epass, elat);
        drive(box, gin, 1'b1);
        @(posedge clk); #1;
        drive(box, gin, 1'b0);
        cyc = 1; seen = 0;
        while (cyc <= 4000) begin
            @(negedge clk);
            if (dut_out(box, 1) === 64'd1) begin seen = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_latency"}, 64'(cyc), 64'(elat));
            chk({tag, "_complete"}, dut_out(box, 2), 64'(ecomp));
            chk({tag, "_contra"}, dut_out(box, 3), 64'(econ));
            chk({tag, "_passes"}, dut_out(box, 4), 64'(epass));
            chk({tag, "_busy_in_done"}, dut_out(box, 0), 64'd1);
            chk({tag, "_grid_diff"}, 64'(grid_diff(box, eg)), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_done_pulse"}, dut_out(box, 1), 64'd0);
            chk({tag, "_idle_busy"}, dut_out(box, 0), 64'd0);
            chk({tag, "_complete_held"}, dut_out(box, 2), 64'(ecomp));
        end
    endtask

    initial begin
        grid_t g, zero, eg;
        bit ecomp, econ;
        int epass, L, d1, d2, nd, nbusy;

        zero = '{default: 0};
        rst_n = 1'b0;
        drive(2, zero, 1'b0);
        drive(3, zero, 1'b0);
        #12;
        for (int b = 2; b <= 3; b++) begin
            for (int k = 0; k < 5; k++) chk($sformatf("reset_b%0d_out%0d", b, k), dut_out(b, k), 64'd0);
            chk($sformatf("reset_b%0d_grid", b), 64'(grid_diff(b, zero)), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        g = sol_grid(2);
        run(2, g, "solved_b2");
        g[3][3] = 4'hF;
        run(2, g, "one_hole_b2");
        g = sol_grid(2);
        g[2][0] = g[0][0];
        run(2, g, "dup_row_b2");
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++) g[x][y] = 9'h1FF;
        run(3, g, "no_givens_b3");

        // Abort a BOX=3 run in the middle of its first elimination pass.
        drive(3, g, 1'b1);
        @(posedge clk); #1;
        drive(3, g, 1'b0);
        repeat (119) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) chk($sformatf("midrst_out%0d", k), dut_out(3, k), 64'd0);
        chk("midrst_grid", 64'(grid_diff(3, zero)), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0; nbusy = 0;
        repeat (200) begin
            @(negedge clk);
            if (if3.o_Done !== 1'b0) nd++;
            if (if3.o_Busy !== 1'b0) nbusy++;
        end
        chk("midrst_no_done", 64'(nd), 64'd0);
        chk("midrst_no_busy", 64'(nbusy), 64'd0);
        @(posedge clk); #1;
        run(3, g, "after_rst_b3");

        // Start held high with random re-pulses while busy.
        g = sol_grid(2);
        g[3][3] = 4'hF;
        model(2, g, eg, ecomp, econ, epass, L);
        drive(2, g, 1'b1);
        @(posedge clk); #1;
        d1 = 0; d2 = 0; nd = 0;
        for (int c = 1; c <= 2 * L + 3; c++) begin
            if (c >= 3 && c <= L - 2) if2.i_Start = 1'($urandom_range(0, 1));
            else if2.i_Start = (c <= L + 1);
            @(negedge clk);
            if (if2.o_Done === 1'b1) begin
                nd++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            if (c == L + 1) begin
                chk("held_idle_busy", dut_out(2, 0), 64'd0);
                chk("held_idle_complete", dut_out(2, 2), 64'(ecomp));
            end
            if (c == L + 2) begin
                chk("held_restart_busy", dut_out(2, 0), 64'd1);
                chk("held_restart_cleared", dut_out(2, 2), 64'd0);
            end
            @(posedge clk); #1;
        end
        chk("held_first_done", 64'(d1), 64'(L));
        chk("held_second_done", 64'(d2), 64'(2 * L + 1));
        chk("held_done_count", 64'(nd), 64'd2);
        chk("held_final_grid", 64'(grid_diff(2, eg)), 64'd0);

        for (int i = 0; i < 24; i++) begin
            if (i < 20) run(2, rand_grid(2), $sformatf("rnd%0d_b2", i));
            else run(3, rand_grid(3), $sformatf("rnd%0d_b3", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
